// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Framebuffer RAM write-port controller. Round-robin arbiter
//               between the pixel-capture stream and the host writer, plus a
//               full-buffer clear sequencer. Every write is funnelled into one
//               registered write port clocked by clk_i.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // capture requester
  input  logic                  cap_valid_i,
  output logic                  cap_ready_o,
  input  logic [ADDR_WIDTH-1:0] cap_addr_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  // host requester
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  // clear control
  input  logic                  clear_start_i,
  input  logic [DATA_WIDTH-1:0] clear_value_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  // RAM write port
  output logic                  wr_enable_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  // Counter is one bit wider than the address so a full-size clear
  // (NUM_WORDS == 1 << ADDR_WIDTH) has an unambiguous terminal value.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state_q,     state_d;
  logic                  last_host_q, last_host_d;  // 1: host was granted most recently
  logic [ADDR_WIDTH:0]   cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] clr_val_q,   clr_val_d;
  logic                  wr_en_q,     wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic                  done_q,      done_d;

  logic                  arb_open;
  logic                  grant_cap;
  logic                  grant_host;

  // Arbitration: a requester wins when alone, or on a tie when it was not
  // the most recent winner. A clear request or reset closes arbitration.
  always_comb begin
    arb_open   = (state_q == ST_ARB) && !clear_start_i && !reset_i;
    grant_cap  = arb_open && cap_valid_i  && (!host_valid_i || last_host_q);
    grant_host = arb_open && host_valid_i && (!cap_valid_i  || !last_host_q);
  end

  assign cap_ready_o  = grant_cap;
  assign host_ready_o = grant_host;

  // Next-state logic: grant capture, clear start and clear sequencing.
  always_comb begin
    state_d     = state_q;
    last_host_d = last_host_q;
    cnt_d       = cnt_q;
    clr_val_d   = clr_val_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clear_start_i) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          clr_val_d = clear_value_i;
        end else if (grant_cap) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = cap_addr_i;
          wr_data_d   = cap_data_i;
          last_host_d = 1'b0;
        end else if (grant_host) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = host_addr_i;
          wr_data_d   = host_data_i;
          last_host_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        // clear_start_i is deliberately ignored here; requests are not queued.
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
        wr_data_d = clr_val_q;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          done_d  = 1'b1;
          state_d = ST_ARB;
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State and write-port registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_ARB;
      last_host_q <= 1'b1;
      cnt_q       <= '0;
      clr_val_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_host_q <= last_host_d;
      cnt_q       <= cnt_d;
      clr_val_q   <= clr_val_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;
  assign wr_enable_o  = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule
`default_nettype wire
